// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared literal/clause/formula types for the DPLL datapath
package common;

    localparam int number_literal = 5;
    localparam int number_clauses = 10;

    typedef struct packed {
        logic [2:0] num;
        logic       val;
    } lit;

    typedef struct packed {
        lit [number_literal-1:0] lits;
        logic [2:0]              len;
    } clause;

    typedef struct packed {
        clause [number_clauses-1:0] clauses;
        logic [3:0]                 len;
    } formula;

    localparam lit     zero_lit     = '0;
    localparam clause  zero_clause  = '0;
    localparam formula zero_formula = '0;

    localparam int lit_w     = $bits(lit);
    localparam int clause_w  = $bits(clause);
    localparam int formula_w = $bits(formula);

    typedef enum logic [1:0] {FS_IDLE, FS_SCAN, FS_DONE} fs_state_t;

    // Polarity is deliberately ignored: the caller decides satisfied vs falsified.
    function automatic logic lit_matches(lit a, lit b);
        return a.num == b.num;
    endfunction

endpackage

// File: rtl/clause_reduce.sv
// rtl/clause_reduce.sv - applies one literal to a clause and compacts the survivors
module clause_reduce
    import common::*;
(
    input  logic [clause_w-1:0] in_clause,
    input  logic [lit_w-1:0]    in_lit,
    output logic                sat,
    output logic [clause_w-1:0] out_clause
);

    clause      c;
    lit         a;
    clause      r;
    logic [2:0] clen;
    logic [2:0] cnt;

    assign c          = clause'(in_clause);
    assign a          = lit'(in_lit);
    assign out_clause = r;

    // cnt is the running prefix count of kept slots, i.e. each survivor's target slot.
    always_comb begin
        r    = zero_clause;
        sat  = 1'b0;
        cnt  = 3'd0;
        clen = (c.len > 3'(number_literal)) ? 3'(number_literal) : c.len;
        for (int i = 0; i < number_literal; i++) begin
            if (3'(i) < clen) begin
                if (lit_matches(c.lits[i], a)) begin
                    if (c.lits[i].val == a.val) sat = 1'b1;
                end else begin
                    r.lits[cnt] = c.lits[i];
                    cnt         = cnt + 3'd1;
                end
            end
        end
        r.len = cnt;
    end

endmodule

// File: rtl/formula_simplify.sv
// rtl/formula_simplify.sv - clause-serial application of one assignment to a formula
module formula_simplify
    import common::*;
#(
    parameter bit EARLY_ABORT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [formula_w-1:0] in_formula,
    input  logic [lit_w-1:0]     in_assign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [formula_w-1:0] out_formula,
    output logic                 out_sat,
    output logic                 out_conflict,
    output logic                 busy
);

    fs_state_t  state, state_next;
    formula     f_in;
    formula     job;
    formula     res;
    lit         asg;
    logic [3:0] in_len, job_len, rd_idx, wr_idx;
    logic       conflict, done_flag;
    logic       cl_sat;
    logic [clause_w-1:0] cl_red_bits;
    clause      cl_red;
    logic       empty, last;

    assign f_in   = formula'(in_formula);
    assign in_len = (f_in.len > 4'(number_clauses)) ? 4'(number_clauses) : f_in.len;

    clause_reduce u_reduce (
        .in_clause  (job.clauses[rd_idx]),
        .in_lit     (asg),
        .sat        (cl_sat),
        .out_clause (cl_red_bits)
    );

    assign cl_red = clause'(cl_red_bits);
    assign empty  = !cl_sat && (cl_red.len == 3'd0);
    assign last   = (rd_idx == job_len - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            FS_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_len == 4'd0) ? FS_DONE : FS_SCAN;
            end
            FS_SCAN: begin
                if (last || (empty && EARLY_ABORT)) state_next = FS_DONE;
            end
            FS_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = FS_IDLE;
            end
            default: state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job       <= zero_formula;
            asg       <= zero_lit;
            job_len   <= 4'd0;
            rd_idx    <= 4'd0;
            wr_idx    <= 4'd0;
            conflict  <= 1'b0;
            done_flag <= 1'b0;
            res       <= zero_formula;
        end else begin
            if (state == FS_IDLE && in_valid) begin
                job       <= f_in;
                asg       <= lit'(in_assign);
                job_len   <= in_len;
                rd_idx    <= 4'd0;
                wr_idx    <= 4'd0;
                conflict  <= 1'b0;
                done_flag <= (in_len == 4'd0);
                res       <= zero_formula;
            end else if (state == FS_SCAN) begin
                rd_idx <= rd_idx + 4'd1;
                // An emptied clause is still stored so downstream sees the conflict site.
                if (!cl_sat) begin
                    res.clauses[wr_idx] <= cl_red;
                    res.len             <= wr_idx + 4'd1;
                    wr_idx              <= wr_idx + 4'd1;
                end
                if (empty) conflict <= 1'b1;
                if (state_next == FS_DONE) done_flag <= 1'b1;
            end
        end
    end

    assign out_formula  = res;
    assign out_conflict = conflict;
    assign out_sat      = done_flag && (wr_idx == 4'd0) && !conflict;
    assign busy         = (state != FS_IDLE);

endmodule

// File: tb/tb_formula_simplify.sv
// tb/tb_formula_simplify.sv - directed-vector bench for formula_simplify
module tb_formula_simplify;
    import common::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid1 = 1'b0, in_valid0 = 1'b0;
    logic out_ready = 1'b0;
    logic [formula_w-1:0] in_formula = '0;
    logic [lit_w-1:0]     in_assign = '0;
    logic in_ready1, out_valid1, out_sat1, out_conflict1, busy1;
    logic in_ready0, out_valid0, out_sat0, out_conflict0, busy0;
    logic [formula_w-1:0] out_formula1, out_formula0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    formula_simplify #(.EARLY_ABORT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_formula(in_formula), .in_assign(in_assign), .out_valid(out_valid1),
        .out_ready(out_ready), .out_formula(out_formula1), .out_sat(out_sat1),
        .out_conflict(out_conflict1), .busy(busy1)
    );

    formula_simplify #(.EARLY_ABORT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_formula(in_formula), .in_assign(in_assign), .out_valid(out_valid0),
        .out_ready(out_ready), .out_formula(out_formula0), .out_sat(out_sat0),
        .out_conflict(out_conflict0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [formula_w-1:0] got,
                       input logic [formula_w-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic lit L(input int num, input int val);
        lit l;
        l.num = 3'(num);
        l.val = 1'(val);
        return l;
    endfunction

    function automatic clause mkc(input int len, input lit l0, input lit l1, input lit l2,
                                  input lit l3, input lit l4);
        clause c;
        c.len     = 3'(len);
        c.lits[0] = l0;
        c.lits[1] = l1;
        c.lits[2] = l2;
        c.lits[3] = l3;
        c.lits[4] = l4;
        return c;
    endfunction

    task automatic run_job(input bit which, input formula f, input lit a, output int lat);
        in_formula = f;
        in_assign  = a;
        if (which) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
        lat = 1;
        while (!(which ? out_valid1 : out_valid0) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    formula f, e, f2;
    lit     z;
    int     lat;

    initial begin
        z = zero_lit;
        #12;
        chk("rst_out_valid", 234'(out_valid1), 234'(0));
        chk("rst_in_ready", 234'(in_ready1), 234'(1));
        chk("rst_busy", 234'(busy1), 234'(0));
        chk("rst_sat", 234'(out_sat1), 234'(0));
        chk("rst_formula", out_formula1, 234'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic drop / shrink, with backpressure and an ignored second request
        f = zero_formula;
        f.clauses[0] = mkc(2, L(1,1), L(2,0), z, z, z);
        f.clauses[1] = mkc(2, L(1,0), L(3,1), z, z, z);
        f.clauses[2] = mkc(1, L(4,1), z, z, z, z);
        f.len = 4'd3;
        e = zero_formula;
        e.clauses[0] = mkc(1, L(3,1), z, z, z, z);
        e.clauses[1] = mkc(1, L(4,1), z, z, z, z);
        e.len = 4'd2;
        run_job(1'b1, f, L(1,1), lat);
        chk("basic_lat", 234'(lat), 234'(4));
        chk("basic_formula", out_formula1, e);
        chk("basic_sat", 234'(out_sat1), 234'(0));
        chk("basic_conflict", 234'(out_conflict1), 234'(0));
        f2 = zero_formula;
        f2.clauses[0] = mkc(1, L(6,1), z, z, z, z);
        in_formula = f2;
        in_assign  = L(6,0);
        in_valid1  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 234'(out_valid1), 234'(1));
            chk("bp_in_ready", 234'(in_ready1), 234'(0));
            chk("bp_formula", out_formula1, e);
        end
        in_valid1 = 1'b0;
        ack();
        chk("bp_idle_in_ready", 234'(in_ready1), 234'(1));
        chk("bp_idle_valid", 234'(out_valid1), 234'(0));
        chk("bp_hold_formula", out_formula1, e);
        run_job(1'b1, f2, L(6,0), lat);
        chk("len0_lat", 234'(lat), 234'(1));
        chk("len0_sat", 234'(out_sat1), 234'(1));
        chk("len0_formula", out_formula1, 234'(0));
        ack();

        // SAT
        f = zero_formula;
        f.clauses[0] = mkc(1, L(2,1), z, z, z, z);
        f.clauses[1] = mkc(2, L(2,1), L(3,0), z, z, z);
        f.len = 4'd2;
        run_job(1'b1, f, L(2,1), lat);
        chk("sat_lat", 234'(lat), 234'(3));
        chk("sat_formula", out_formula1, 234'(0));
        chk("sat_sat", 234'(out_sat1), 234'(1));
        chk("sat_conflict", 234'(out_conflict1), 234'(0));
        ack();

        // conflict, both abort modes
        f = zero_formula;
        f.clauses[0] = mkc(1, L(3,0), z, z, z, z);
        f.clauses[1] = mkc(1, L(4,1), z, z, z, z);
        f.clauses[2] = mkc(1, L(5,1), z, z, z, z);
        f.len = 4'd3;
        e = zero_formula;
        e.len = 4'd1;
        run_job(1'b1, f, L(3,1), lat);
        chk("ea1_lat", 234'(lat), 234'(2));
        chk("ea1_conflict", 234'(out_conflict1), 234'(1));
        chk("ea1_sat", 234'(out_sat1), 234'(0));
        chk("ea1_formula", out_formula1, e);
        ack();
        e.clauses[1] = mkc(1, L(4,1), z, z, z, z);
        e.clauses[2] = mkc(1, L(5,1), z, z, z, z);
        e.len = 4'd3;
        run_job(1'b0, f, L(3,1), lat);
        chk("ea0_lat", 234'(lat), 234'(4));
        chk("ea0_conflict", 234'(out_conflict0), 234'(1));
        chk("ea0_formula", out_formula0, e);
        ack();

        // formula len 15 clamps to 10
        f = zero_formula;
        e = zero_formula;
        for (int i = 0; i < number_clauses; i++) begin
            f.clauses[i] = mkc(1, L(i % 6 + 2, i % 2), z, z, z, z);
            e.clauses[i] = f.clauses[i];
        end
        f.len = 4'd15;
        e.len = 4'd10;
        run_job(1'b1, f, L(1,1), lat);
        chk("flen_lat", 234'(lat), 234'(11));
        chk("flen_formula", out_formula1, e);
        ack();

        // clause len 7 clamps to 5; slots beyond len are ignored
        f = zero_formula;
        f.clauses[0] = mkc(7, L(1,0), L(2,1), L(3,1), L(4,0), L(5,1));
        f.clauses[1] = mkc(1, L(6,1), L(1,1), z, z, z);
        f.len = 4'd2;
        e = zero_formula;
        e.clauses[0] = mkc(4, L(1,0), L(2,1), L(4,0), L(5,1), z);
        e.clauses[1] = mkc(1, L(6,1), z, z, z, z);
        e.len = 4'd2;
        run_job(1'b1, f, L(3,0), lat);
        chk("clen_lat", 234'(lat), 234'(3));
        chk("clen_formula", out_formula1, e);
        ack();

        // both polarities in one clause counts as satisfied
        f = zero_formula;
        f.clauses[0] = mkc(2, L(2,0), L(2,1), z, z, z);
        f.clauses[1] = mkc(1, L(5,0), z, z, z, z);
        f.len = 4'd2;
        e = zero_formula;
        e.clauses[0] = mkc(1, L(5,0), z, z, z, z);
        e.len = 4'd1;
        run_job(1'b1, f, L(2,0), lat);
        chk("both_formula", out_formula1, e);
        chk("both_conflict", 234'(out_conflict1), 234'(0));
        ack();

        // async reset in the second SCAN cycle
        f = zero_formula;
        f.clauses[0] = mkc(1, L(4,1), z, z, z, z);
        f.clauses[1] = mkc(1, L(3,0), z, z, z, z);
        f.clauses[2] = mkc(1, L(5,1), z, z, z, z);
        f.len = 4'd3;
        in_formula = f;
        in_assign  = L(3,1);
        in_valid1  = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 234'(busy1), 234'(0));
        chk("mrst_in_ready", 234'(in_ready1), 234'(1));
        chk("mrst_valid", 234'(out_valid1), 234'(0));
        chk("mrst_conflict", 234'(out_conflict1), 234'(0));
        chk("mrst_formula", out_formula1, 234'(0));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        f = zero_formula;
        f.clauses[0] = mkc(2, L(7,1), L(1,0), z, z, z);
        f.len = 4'd1;
        e = zero_formula;
        e.clauses[0] = mkc(1, L(7,1), z, z, z, z);
        e.len = 4'd1;
        run_job(1'b1, f, L(1,1), lat);
        chk("post_rst_lat", 234'(lat), 234'(2));
        chk("post_rst_formula", out_formula1, e);
        chk("post_rst_conflict", 234'(out_conflict1), 234'(0));
        chk("post_rst_sat", 234'(out_sat1), 234'(0));
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/formula_simplify.md
Name: formula_simplify

Overview:
- Clause-serial simplification stage of the DPLL datapath. Applies one literal assignment (decision or unit) to a common::formula: satisfied clauses are dropped, falsified literals are removed, and survivors are compacted.
- Sits between the decision/unit-select logic (upstream) and the formula stack (downstream). Processes one clause per cycle. Uses valid/ready on both sides.

Parameters:
- EARLY_ABORT, 1, when 1 the stage stops at the first clause reduced to length 0 (conflict) instead of scanning the rest.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  1  in_formula/in_assign valid.
- in_ready  out  1  stage can accept (IDLE only).
- in_formula  in  234 (common::formula)  formula to simplify.
- in_assign  in  4 (common::lit)  assignment: variable num takes value val.
- out_valid  out  1  result valid. Held until out_ready.
- out_ready  in  1  downstream accepts.
- out_formula  out  234 (common::formula)  simplified formula.
- out_sat  out  1  out_formula.len==0 and no conflict.
- out_conflict  out  1  some clause was reduced to length 0.
- busy  out  1  state!=IDLE.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Literal semantics:
  - A lit matches the assignment when num==in_assign.num.
  - The clause is satisfied if a matching lit has val==in_assign.val.
  - A matching lit with val!=in_assign.val is falsified and removed.
  - Only lits[0..len-1] are valid. Clause len>number_literal is clamped to number_literal. Formula len>number_clauses is clamped to number_clauses.
- States: IDLE, SCAN, DONE.
- Reset (any time, including mid-SCAN or DONE):
  - State goes to IDLE; in_ready=1, out_valid=0, out_sat=0, out_conflict=0, busy=0.
  - out_formula=zero_formula; the index and write counters go to 0.
  - An in-flight job is discarded and not replayed.
- IDLE:
  - in_ready=1. On in_valid&&in_ready (cycle T), latch the formula and assignment, clear the out_formula register to zero_formula, and set rd_idx=0, wr_idx=0.
  - If clamped len==0, go to DONE, else go to SCAN.
- SCAN, one clause per cycle (clause rd_idx):
  - Satisfied: discard it; wr_idx unchanged.
  - Otherwise: write the reduced clause to out_formula.clauses[wr_idx] and increment wr_idx.
    - Reduced clause = surviving lits packed to slots 0..k-1 in original order, slots k.. = zero_lit, len=k.
  - If k==0: set conflict. If EARLY_ABORT=1, go to DONE this cycle (the empty clause is stored and counted).
  - rd_idx==len-1: go to DONE.
- DONE:
  - out_valid=1; out_formula.len=wr_idx; out_conflict as accumulated; out_sat=(wr_idx==0)&&!conflict.
  - Outputs are stable while out_valid&&!out_ready.
  - On out_ready, return to IDLE the next cycle. out_valid drops; data outputs hold their last value.
- Latency: accept at T; out_valid at T+N+1 for N scanned clauses (T+1 if len==0). Throughput is one job per N+2 cycles.
- in_ready=0 outside IDLE; in_valid there is ignored, and the upstream must hold its inputs.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.
- A clause containing both polarities of the assigned variable counts as satisfied.
- wr_idx never exceeds rd_idx, so no overflow is possible.

Decomposition:
- Stays in package common: lit, clause, formula, zero_* constants.
- Add to common:
  - typedef enum logic[1:0] {FS_IDLE, FS_SCAN, FS_DONE} fs_state_t.
  - function lit_matches(lit a, lit b).
- One combinational sub-module, clause_reduce:
  - Inputs: clause and lit.
  - Outputs: satisfied flag and reduced (compacted, zero-padded) clause.
  - A prefix-count compaction network over number_literal slots; it is also reused by the unit-propagation stage.

Test Plan:
- Basic drop/shrink: clauses {(1,1)(2,0)}, {(1,0)(3,1)}, {(4,1)}, len=3; assign (1,1). Required: out_formula.len=2, clause0={(3,1)} len1, clause1={(4,1)} len1; sat=0, conflict=0; out_valid at T+4.
- SAT: clauses {(2,1)}, {(2,1)(3,0)}, len=2; assign (2,1). Required: len=0, all clauses zero_clause, out_sat=1, conflict=0.
- Conflict with EARLY_ABORT=1: clauses {(3,0)}, {(4,1)}, {(5,1)}; assign (3,1). Required: out_valid at T+2, conflict=1, len=1, clause0 len0. With EARLY_ABORT=0: out_valid at T+4, len=3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: outputs stable, in_ready=0, a second in_valid is ignored; out_ready=1 leads to IDLE next cycle, and the second job is then accepted.
- Edges:
  - Formula len=0 gives out_valid at T+1, sat=1.
  - Formula len=15 is clamped to 10 scanned clauses.
  - Clause len=7 is clamped to 5.
  - Clause with (2,0)(2,1) under assign (2,0) is dropped.
- Reset mid-SCAN: assert rst_n=0 asynchronously in the 2nd SCAN cycle. Required: immediate IDLE, outputs zero; the next job completes correctly with no residue from the aborted one.
